// File: rtl/lzd_seq_ctrl.sv
// Sequencer for the 61-bit LZD: chains all-zero words into one wide leading-zero count.
// Latency: word accepted -> result valid 3 cycles later; each extra all-zero word adds 3 cycles + input wait.
// Backpressure: u_ready only in IDLE; the result is held in DONE until res_ready.
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   u_valid/u_ready     uniform-word input stream, u_data[60] is the MSB
//   lzd_en/lzd_in       drive the external LZD; lzd_pos is its registered count (one cycle later)
//   res_valid/res_ready result stream: res_lz total zeros, res_word last word, res_sat all words zero
// Optional build macro LZD_SEQ_STATS_EN adds free-running counters stat_res / stat_ext.
module lzd_seq_ctrl #(
    parameter int MAX_EXT = 4,
    parameter int LZW     = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            u_valid,
    input  logic [60:0]     u_data,
    output logic            u_ready,
    output logic            lzd_en,
    output logic [60:0]     lzd_in,
    input  logic [5:0]      lzd_pos,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [LZW-1:0]  res_lz,
    output logic [60:0]     res_word,
    output logic            res_sat
`ifdef LZD_SEQ_STATS_EN
    ,
    output logic [31:0]     stat_res,
    output logic [31:0]     stat_ext
`endif
);

    localparam int         EXTW     = (MAX_EXT > 1) ? $clog2(MAX_EXT) : 1;
    localparam logic [5:0] ALL_ZERO = 6'd61;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LZW-1:0]    acc_q,   acc_d;
    logic [EXTW-1:0]   ext_q,   ext_d;
    logic              sat_q,   sat_d;
    logic [60:0]       word_q,  word_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ext_q   <= '0;
            sat_q   <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ext_q   <= ext_d;
            sat_q   <= sat_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ext_d     = ext_q;
        sat_d     = sat_q;
        word_d    = word_q;
        u_ready   = 1'b0;
        lzd_en    = 1'b0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is masked by rst so nothing is accepted while reset is held.
                u_ready = ~rst;
                if (u_valid && !rst) begin
                    word_d  = u_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lzd_en  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (lzd_pos == ALL_ZERO) begin
                    acc_d = acc_q + LZW'(ALL_ZERO);
                    if (ext_q == EXTW'(MAX_EXT - 1)) begin
                        sat_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Keep the partial count and fetch the next word to extend it.
                        ext_d   = ext_q + EXTW'(1);
                        state_d = IDLE;
                    end
                end else begin
                    acc_d   = acc_q + LZW'(lzd_pos);
                    state_d = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    acc_d   = '0;
                    ext_d   = '0;
                    sat_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The LZD operand is simply the captured word; it only matters while lzd_en is high.
    assign lzd_in   = word_q;
    assign res_lz   = acc_q;
    assign res_word = word_q;
    assign res_sat  = sat_q;

`ifdef LZD_SEQ_STATS_EN
    logic [31:0] stat_res_q, stat_ext_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_res_q <= '0;
            stat_ext_q <= '0;
        end else begin
            if (state_q == DONE && res_ready) begin
                stat_res_q <= stat_res_q + 32'd1;
            end
            if (state_q == WAIT && lzd_pos == ALL_ZERO) begin
                stat_ext_q <= stat_ext_q + 32'd1;
            end
        end
    end

    assign stat_res = stat_res_q;
    assign stat_ext = stat_ext_q;
`endif

endmodule

// File: tb/tb_lzd_seq_ctrl.sv
// Self-checking bench for lzd_seq_ctrl with a behavioural registered LZD and a result scoreboard.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with LZD_SEQ_STATS_EN defined to also check the statistics counters.
module tb_lzd_seq_ctrl;

    localparam int MAX_EXT = 4;
    localparam int LZW     = 9;

    typedef struct packed {
        logic [LZW-1:0] lz;
        logic [60:0]    word;
        logic           sat;
    } res_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           u_valid;
    logic [60:0]    u_data;
    logic           u_ready;
    logic           lzd_en;
    logic [60:0]    lzd_in;
    logic [5:0]     lzd_pos;
    logic           res_valid;
    logic           res_ready;
    logic [LZW-1:0] res_lz;
    logic [60:0]    res_word;
    logic           res_sat;
`ifdef LZD_SEQ_STATS_EN
    logic [31:0]    stat_res;
    logic [31:0]    stat_ext;
`endif

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    int   m_acc = 0;
    int   m_zeros = 0;
    int   e_stat_res = 0;
    int   e_stat_ext = 0;

    lzd_seq_ctrl #(.MAX_EXT(MAX_EXT), .LZW(LZW)) dut (
        .clk(clk), .rst(rst),
        .u_valid(u_valid), .u_data(u_data), .u_ready(u_ready),
        .lzd_en(lzd_en), .lzd_in(lzd_in), .lzd_pos(lzd_pos),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_lz(res_lz), .res_word(res_word), .res_sat(res_sat)
`ifdef LZD_SEQ_STATS_EN
        , .stat_res(stat_res), .stat_ext(stat_ext)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] clz61(input logic [60:0] w);
        for (int i = 60; i >= 0; i--) begin
            if (w[i]) return 6'(60 - i);
        end
        return 6'd61;
    endfunction

    // Registered LZD: result one cycle after enable, zero whenever enable is low.
    always @(posedge clk or posedge rst) begin
        if (rst) lzd_pos <= '0;
        else     lzd_pos <= lzd_en ? clz61(lzd_in) : 6'd0;
    end

    // Reference model: pushes the expected result once a word completes a count.
    task automatic model_word(input logic [60:0] w, output bit done);
        res_t e;
        done = 1'b0;
        if (w == 61'd0) begin
            m_acc += 61;
            m_zeros++;
            e_stat_ext++;
            if (m_zeros == MAX_EXT) begin
                e.lz = LZW'(m_acc); e.word = w; e.sat = 1'b1;
                exp_q.push_back(e);
                done = 1'b1;
            end
        end else begin
            m_acc += int'(clz61(w));
            e.lz = LZW'(m_acc); e.word = w; e.sat = 1'b0;
            exp_q.push_back(e);
            done = 1'b1;
        end
        if (done) begin
            m_acc = 0;
            m_zeros = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake (ISSUE cycle).
    task automatic send_word(input logic [60:0] w, output bit to);
        to = 1'b1;
        u_valid = 1'b1;
        u_data  = w;
        for (int n = 0; n < 200; n++) begin
            if (u_ready) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        u_valid = 1'b0;
    endtask

    // Waits for res_valid, captures the result, then takes it with a one-cycle res_ready.
    task automatic get_result(output res_t r, output int cyc, output bit to);
        to = 1'b1;
        cyc = 0;
        r = '0;
        for (int n = 0; n < 200; n++) begin
            if (res_valid) begin
                to = 1'b0;
                r.lz = res_lz; r.word = res_word; r.sat = res_sat;
                cyc = n;
                break;
            end
            @(negedge clk);
        end
        if (!to) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            e_stat_res++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; u_valid = 1'b0; u_data = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (u_ready !== 1'b0)   begin errors++; $display("FAIL reset_u_ready: got %0b want 0", u_ready); end
        checks++; if (lzd_en !== 1'b0)    begin errors++; $display("FAIL reset_lzd_en: got %0b want 0", lzd_en); end
        checks++; if (lzd_in !== 61'd0)   begin errors++; $display("FAIL reset_lzd_in: got %0h want 0", lzd_in); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b want 0", res_valid); end
        checks++; if ({res_lz, res_word, res_sat} !== '0) begin errors++; $display("FAIL reset_res: got %0h/%0h/%0b want 0", res_lz, res_word, res_sat); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (u_ready !== 1'b1)   begin errors++; $display("FAIL idle_u_ready: got %0b want 1", u_ready); end
    endtask

    task automatic test_msb();
        res_t r, e; int cyc; bit to, d;
        logic [60:0] w = 61'h1000_0000_0000_0000;
        model_word(w, d);
        send_word(w, to);
        checks++; if (to) begin errors++; $display("FAIL msb_accept: got timeout want handshake"); end
        checks++; if (lzd_en !== 1'b1) begin errors++; $display("FAIL msb_lzd_en: got %0b want 1", lzd_en); end
        checks++; if (lzd_in !== w)    begin errors++; $display("FAIL msb_lzd_in: got %0h want %0h", lzd_in, w); end
        get_result(r, cyc, to);
        e = exp_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL msb_result: got timeout want res_valid"); end
        checks++; if (cyc !== 2)       begin errors++; $display("FAIL msb_latency: got %0d want 2 cycles after ISSUE", cyc); end
        checks++; if (r !== e)         begin errors++; $display("FAIL msb_res: got %0d/%0h/%0b want %0d/%0h/%0b", r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
    endtask

    task automatic test_lsb();
        res_t r, e; int cyc; bit to, d;
        model_word(61'h1, d);
        send_word(61'h1, to);
        get_result(r, cyc, to);
        e = exp_q.pop_front();
        checks++; if (to || r !== e) begin errors++; $display("FAIL lsb_res: got %0d/%0h/%0b want %0d/%0h/%0b", r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
    endtask

    task automatic test_chain();
        res_t r, e; int cyc; bit to, to2, d;
        model_word(61'h0, d);
        send_word(61'h0, to);
        model_word(61'hF0, d);
        send_word(61'hF0, to2);
        checks++; if (to || to2) begin errors++; $display("FAIL chain_accept: got timeout %0b/%0b want 0/0", to, to2); end
        get_result(r, cyc, to);
        e = exp_q.pop_front();
        checks++; if (to || r !== e) begin errors++; $display("FAIL chain_res: got %0d/%0h/%0b want %0d/%0h/%0b", r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
    endtask

    task automatic test_saturate();
        res_t r, e; int cyc; bit to, d;
        for (int i = 0; i < MAX_EXT; i++) begin
            model_word(61'h0, d);
            send_word(61'h0, to);
        end
        repeat (2) @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b want 1", res_valid); end
        checks++; if (u_ready !== 1'b0)   begin errors++; $display("FAIL sat_u_ready: got %0b want 0", u_ready); end
        get_result(r, cyc, to);
        e = exp_q.pop_front();
        checks++; if (to || r !== e) begin errors++; $display("FAIL sat_res: got %0d/%0h/%0b want %0d/%0h/%0b", r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
        checks++; if (u_ready !== 1'b1)   begin errors++; $display("FAIL sat_after_take: got u_ready %0b want 1", u_ready); end
    endtask

    task automatic test_stats();
`ifdef LZD_SEQ_STATS_EN
        checks++; if (stat_res !== 32'(e_stat_res)) begin errors++; $display("FAIL stat_res: got %0d want %0d", stat_res, e_stat_res); end
        checks++; if (stat_ext !== 32'(e_stat_ext)) begin errors++; $display("FAIL stat_ext: got %0d want %0d", stat_ext, e_stat_ext); end
`endif
    endtask

    task automatic test_stall();
        res_t r, e; int cyc; bit to, d;
        logic [60:0] w = 61'h0000_0000_0001_2345;
        model_word(w, d);
        send_word(w, to);
        e = exp_q.pop_front();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_lz !== e.lz || res_word !== w || u_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%0b lz=%0d w=%0h rdy=%0b want v=1 lz=%0d w=%0h rdy=0", i, res_valid, res_lz, res_word, u_ready, e.lz, w);
            end
            @(negedge clk);
        end
        get_result(r, cyc, to);
        checks++; if (to || r !== e) begin errors++; $display("FAIL stall_res: got %0d/%0h/%0b want %0d/%0h/%0b", r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
        checks++; if (u_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL stall_handoff: got rdy=%0b v=%0b want 1/0", u_ready, res_valid); end
    endtask

    task automatic test_reset_mid();
        res_t r, e; int cyc; bit to, d;
        send_word(61'h0, to);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (u_ready !== 1'b0 || lzd_en !== 1'b0 || res_valid !== 1'b0 || {res_lz, res_word, res_sat} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%0b en=%0b v=%0b lz=%0d w=%0h s=%0b want all 0", u_ready, lzd_en, res_valid, res_lz, res_word, res_sat);
        end
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0; m_zeros = 0; e_stat_res = 0; e_stat_ext = 0;
        test_stats();
        model_word(61'h1, d);
        send_word(61'h1, to);
        get_result(r, cyc, to);
        e = exp_q.pop_front();
        checks++; if (to || r !== e) begin errors++; $display("FAIL midreset_res: got %0d/%0h/%0b want %0d/%0h/%0b", r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
    endtask

    task automatic test_back_to_back();
        res_t r, e; int cyc; bit to, d;
        logic [60:0] w;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                w = '0;
            end else begin
                w = {29'($urandom), 32'($urandom)} >> $urandom_range(0, 60);
                if (w == '0) w = 61'h1;
            end
            model_word(w, d);
            send_word(w, to);
            if (d) begin
                get_result(r, cyc, to);
                e = exp_q.pop_front();
                checks++; if (to || r !== e) begin errors++; $display("FAIL b2b_res[%0d]: got %0d/%0h/%0b want %0d/%0h/%0b", i, r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
            end
        end
        if (m_zeros != 0) begin
            model_word(61'h3, d);
            send_word(61'h3, to);
            get_result(r, cyc, to);
            e = exp_q.pop_front();
            checks++; if (to || r !== e) begin errors++; $display("FAIL b2b_flush: got %0d/%0h/%0b want %0d/%0h/%0b", r.lz, r.word, r.sat, e.lz, e.word, e.sat); end
        end
    endtask

    initial begin
        test_reset();
        test_msb();
        test_lsb();
        test_chain();
        test_saturate();
        test_stats();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
